// File: rtl/gpr_sb.sv
// gpr_sb: parametrised MIPS general-purpose register file.
// It has two combinational read ports, one write port, optional same-cycle
// write-to-read bypass, a per-register pending-write scoreboard and a
// committed-write counter.
module gpr_sb #(
   parameter int          DW      = 32,
   parameter int          AW      = 5,
   parameter int          BYPASS  = 1,
   parameter int          GP_IDX  = 28,
   parameter int          SP_IDX  = 29,
   parameter logic [31:0] GP_INIT = 32'h0000_1800,
   parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
   parameter int          CW      = 32
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic [AW-1:0] A1,
   input  logic [AW-1:0] A2,
   output logic [DW-1:0] RD1,
   output logic [DW-1:0] RD2,
   input  logic          We,
   input  logic [AW-1:0] A3,
   input  logic [DW-1:0] WD,
   input  logic          Iss,
   input  logic [AW-1:0] IssA,
   output logic          Busy1,
   output logic          Busy2,
   output logic [CW-1:0] WrCnt
);

   localparam int Depth = 1 << AW;

   // An init index of 0 or one that does not fit the array is ignored.
   localparam bit GpOk = (GP_IDX > 0) && (GP_IDX < Depth);
   localparam bit SpOk = (SP_IDX > 0) && (SP_IDX < Depth);

   localparam logic [DW-1:0] GpVal = DW'(GP_INIT);
   localparam logic [DW-1:0] SpVal = DW'(SP_INIT);

   logic [DW-1:0] regs [0:Depth-1];
   logic [Depth-1:0] busy;

   logic writeOk;
   logic issueOk;

   assign writeOk = We && (A3 != '0);
   assign issueOk = Iss && (IssA != '0);

   // Reset value of register i: GP/SP init values where enabled, else zero.
   function automatic logic [DW-1:0] initVal(input int i);
      logic [DW-1:0] v;
      v = '0;
      if (GpOk && (i == GP_IDX))
         v = GpVal;
      if (SpOk && (i == SP_IDX))
         v = SpVal;
      return v;
   endfunction

   // Register array: reset to init values; writes to register 0 are dropped.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < Depth; i++)
            regs[i] <= initVal(i);
      end else if (writeOk) begin
         regs[A3] <= WD;
      end
   end

   // Scoreboard: a commit clears the bit, an issue sets it. The issue comes
   // last so it wins when both target the same register on one edge.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         busy <= '0;
      end else begin
         if (writeOk)
            busy[A3] <= 1'b0;
         if (issueOk)
            busy[IssA] <= 1'b1;
      end
   end

   // Committed-write counter; wraps naturally at 2**CW.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         WrCnt <= '0;
      else if (writeOk)
         WrCnt <= WrCnt + CW'(1);
   end

   // Read port 1: zero register, then bypass of the in-flight write, then the array.
   always_comb begin
      RD1   = '0;
      Busy1 = 1'b0;
      if (A1 != '0) begin
         if ((BYPASS != 0) && We && (A3 == A1)) begin
            RD1   = WD;
            Busy1 = 1'b0;
         end else begin
            RD1   = regs[A1];
            Busy1 = busy[A1];
         end
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      RD2   = '0;
      Busy2 = 1'b0;
      if (A2 != '0) begin
         if ((BYPASS != 0) && We && (A3 == A2)) begin
            RD2   = WD;
            Busy2 = 1'b0;
         end else begin
            RD2   = regs[A2];
            Busy2 = busy[A2];
         end
      end
   end

endmodule

// File: tb/tb_gpr_sb.sv
// tb_gpr_sb: self-checking bench for gpr_sb.
// It uses a bypass instance, a non-bypass twin sharing its inputs, and a
// small-parameter instance.
module tb_gpr_sb;

   logic        Clk;
   logic        clkEn;
   logic        Rst;
   logic [4:0]  A1, A2, A3, IssA;
   logic [31:0] WD;
   logic        We, Iss;
   logic [31:0] RD1, RD2, nbRD1, nbRD2;
   logic        Busy1, Busy2, nbBusy1, nbBusy2;
   logic [31:0] WrCnt, nbWrCnt;

   logic [2:0]  pA1, pA2, pA3, pIssA;
   logic [15:0] pWD, pRD1, pRD2;
   logic        pWe, pIss, pBusy1, pBusy2;
   logic [3:0]  pWrCnt;

   int nCompared;
   int nMismatch;

   // Reference model of the default-size register file.
   logic [31:0] mReg [32];
   bit          mBusy [32];
   logic [31:0] mCnt;

   typedef struct {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  issa;
      logic [4:0]  a1;
      logic [31:0] expRd;
      logic        expBusy;
      logic [31:0] expNbRd;
      logic        expNbBusy;
      logic [31:0] expCnt;
   } vec_t;

   vec_t vecs [14];

   gpr_sb dut (
      .Clk(Clk), .Rst(Rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .We(We), .A3(A3), .WD(WD), .Iss(Iss), .IssA(IssA),
      .Busy1(Busy1), .Busy2(Busy2), .WrCnt(WrCnt)
   );

   gpr_sb #(.BYPASS(0)) dutNb (
      .Clk(Clk), .Rst(Rst), .A1(A1), .A2(A2), .RD1(nbRD1), .RD2(nbRD2),
      .We(We), .A3(A3), .WD(WD), .Iss(Iss), .IssA(IssA),
      .Busy1(nbBusy1), .Busy2(nbBusy2), .WrCnt(nbWrCnt)
   );

   gpr_sb #(.DW(16), .AW(3), .GP_IDX(6), .GP_INIT(32'h0000_00AA), .SP_IDX(29), .CW(4)) dutP (
      .Clk(Clk), .Rst(Rst), .A1(pA1), .A2(pA2), .RD1(pRD1), .RD2(pRD2),
      .We(pWe), .A3(pA3), .WD(pWD), .Iss(pIss), .IssA(pIssA),
      .Busy1(pBusy1), .Busy2(pBusy2), .WrCnt(pWrCnt)
   );

   // Free-running clock that can be held low during the stopped-clock reset check.
   initial Clk = 1'b0;
   always begin
      #5;
      if (clkEn)
         Clk = ~Clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                input logic iss, input logic [4:0] issa,
                                input logic [4:0] a1, input logic [4:0] a2);
      We = we; A3 = a3; WD = wd; Iss = iss; IssA = issa; A1 = a1; A2 = a2;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         mReg[i]  = '0;
         mBusy[i] = 1'b0;
      end
      mReg[28] = 32'h0000_1800;
      mReg[29] = 32'h0000_2ffc;
      mCnt = '0;
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && We && A3 == a) return WD;
      return mReg[a];
   endfunction

   function automatic logic expBusy(input logic [4:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && We && A3 == a) return 1'b0;
      return mBusy[a];
   endfunction

   task automatic modelEdge();
      if (We && A3 != 0) begin
         mReg[A3]  = WD;
         mBusy[A3] = 1'b0;
         mCnt      = mCnt + 1;
      end
      if (Iss && IssA != 0)
         mBusy[IssA] = 1'b1;
   endtask

   initial begin
      nCompared = 0;
      nMismatch = 0;
      clkEn = 1'b0;
      Rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd28, 5'd29);
      pWe = 1'b0; pA3 = '0; pWD = '0; pIss = 1'b0; pIssA = '0; pA1 = 3'd6; pA2 = 3'd5;

      // Reset contents with the clock stopped.
      #2;
      checkOutput("rst_gp", RD1, 32'h0000_1800);
      checkOutput("rst_sp", RD2, 32'h0000_2ffc);
      checkOutput("rst_busy1", Busy1, 1'b0);
      checkOutput("rst_busy2", Busy2, 1'b0);
      checkOutput("rst_wrcnt", WrCnt, 32'd0);
      A1 = 5'd5;
      #1;
      checkOutput("rst_r5", RD1, 32'd0);
      checkOutput("p_rst_gp", pRD1, 16'h00AA);
      checkOutput("p_rst_sp_ignored", pRD2, 16'h0000);
      checkOutput("p_rst_wrcnt", pWrCnt, 4'd0);
      Rst = 1'b0;
      #2;
      clkEn = 1'b1;

      // Directed table: expectations sampled before the edge of each vector.
      vecs[0]  = '{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'd0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd1};
      vecs[2]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'd1};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9, 32'h0,         1'b0, 32'h0,         1'b0, 32'd1};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 32'h0,         1'b1, 32'h0,         1'b1, 32'd1};
      vecs[5]  = '{1'b1, 5'd9, 32'h1234,      1'b0, 5'd0, 5'd9, 32'h1234,      1'b0, 32'h0,         1'b1, 32'd1};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 32'h1234,      1'b0, 32'h1234,      1'b0, 32'd2};
      vecs[7]  = '{1'b1, 5'd9, 32'h5678,      1'b1, 5'd9, 5'd9, 32'h5678,      1'b0, 32'h1234,      1'b0, 32'd2};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 32'h5678,      1'b1, 32'h5678,      1'b1, 32'd3};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9, 32'h5678,      1'b1, 32'h5678,      1'b1, 32'd3};
      vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 32'h5678,      1'b1, 32'h5678,      1'b1, 32'd3};
      vecs[11] = '{1'b1, 5'd9, 32'hAAAA,      1'b1, 5'd3, 5'd9, 32'hAAAA,      1'b0, 32'h5678,      1'b1, 32'd3};
      vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 32'h0,         1'b1, 32'h0,         1'b1, 32'd4};
      vecs[13] = '{1'b1, 5'd4, 32'h5,         1'b0, 5'd0, 5'd9, 32'hAAAA,      1'b0, 32'hAAAA,      1'b0, 32'd4};

      for (int v = 0; v < 14; v++) begin
         @(negedge Clk);
         applyStimulus(vecs[v].we, vecs[v].a3, vecs[v].wd, vecs[v].iss, vecs[v].issa, vecs[v].a1, vecs[v].a1);
         #1;
         checkOutput($sformatf("vec%0d_rd1", v), RD1, vecs[v].expRd);
         checkOutput($sformatf("vec%0d_rd2", v), RD2, vecs[v].expRd);
         checkOutput($sformatf("vec%0d_busy1", v), Busy1, vecs[v].expBusy);
         checkOutput($sformatf("vec%0d_nb_rd1", v), nbRD1, vecs[v].expNbRd);
         checkOutput($sformatf("vec%0d_nb_busy1", v), nbBusy1, vecs[v].expNbBusy);
         checkOutput($sformatf("vec%0d_wrcnt", v), WrCnt, vecs[v].expCnt);
      end

      // Asynchronous reset between edges, held across one edge carrying a write and an issue.
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
      #1;
      checkOutput("pre_rst_busy3", Busy1, 1'b1);
      checkOutput("pre_rst_r4", nbRD2, 32'd5);
      checkOutput("pre_rst_wrcnt", WrCnt, 32'd5);
      applyStimulus(1'b1, 5'd4, 32'd77, 1'b1, 5'd5, 5'd3, 5'd4);
      #1;
      Rst = 1'b1;
      #1;
      checkOutput("rst_mid_busy3", Busy1, 1'b0);
      checkOutput("rst_mid_r4", nbRD2, 32'd0);
      checkOutput("rst_mid_wrcnt", WrCnt, 32'd0);
      @(posedge Clk);
      #1;
      A1 = 5'd5;
      #1;
      checkOutput("rst_edge_wrcnt", WrCnt, 32'd0);
      checkOutput("rst_edge_r4", nbRD2, 32'd0);
      checkOutput("rst_edge_busy5", Busy1, 1'b0);
      @(negedge Clk);
      Rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd28, 5'd0);
      #1;
      checkOutput("post_rst_gp", RD1, 32'h0000_1800);
      modelReset();

      // Randomised traffic against the reference model; small addresses are
      // favoured to provoke collisions.
      for (int c = 0; c < 400; c++) begin
         @(negedge Clk);
         applyStimulus(($urandom_range(0, 99) < 50),
                       5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                       $urandom,
                       ($urandom_range(0, 99) < 40),
                       5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                       5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                       5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)));
         #1;
         checkOutput("rnd_rd1", RD1, expRead(A1, 1'b1));
         checkOutput("rnd_rd2", RD2, expRead(A2, 1'b1));
         checkOutput("rnd_busy1", Busy1, expBusy(A1, 1'b1));
         checkOutput("rnd_busy2", Busy2, expBusy(A2, 1'b1));
         checkOutput("rnd_nb_rd1", nbRD1, expRead(A1, 1'b0));
         checkOutput("rnd_nb_busy2", nbBusy2, expBusy(A2, 1'b0));
         checkOutput("rnd_wrcnt", WrCnt, mCnt);
         modelEdge();
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Small instance: 17 counted writes wrap a 4-bit counter to 1; a write to r0 is not counted.
      for (int k = 0; k < 17; k++) begin
         @(negedge Clk);
         pWe = 1'b1;
         pA3 = 3'((k % 7) + 1);
         pWD = 16'(k);
      end
      @(negedge Clk);
      pA3 = 3'd0;
      pWD = 16'hFFFF;
      @(negedge Clk);
      pWe = 1'b0;
      pA1 = 3'd3;
      pA2 = 3'd6;
      pIss = 1'b1;
      pIssA = 3'd6;
      #1;
      checkOutput("p_wrcnt_wrap", pWrCnt, 4'd1);
      checkOutput("p_r3", pRD1, 16'd16);
      checkOutput("p_r6", pRD2, 16'd12);
      checkOutput("p_busy6_before", pBusy2, 1'b0);
      @(negedge Clk);
      pIss = 1'b0;
      #1;
      checkOutput("p_busy6_after", pBusy2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
